// File: rtl/ring_osc_meter_pkg.sv
// ring_osc_pkg: shared types and helpers for the ring-oscillator meter.
//   state_t    - scan FSM states
//   ch_sel_t   - result of a channel search (found flag + index)
//   stages_of  - inverter count of a given channel
//   next_ch    - lowest set mask bit at or above a start position
`timescale 1ns/1ps
package ring_osc_pkg;

  // Upper bound on channel count; masks are zero-extended to this width
  // so one search function serves every N_CH.
  localparam int MAX_CH = 32;

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, REPORT, DONE} state_t;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } ch_sel_t;

  function automatic int stages_of(input int no_stages, input int c);
    return no_stages + 2 * c;
  endfunction

  // Scan from the top down so the lowest qualifying bit is the one kept.
  function automatic ch_sel_t next_ch(input logic [MAX_CH-1:0] mask, input int from);
    ch_sel_t r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) begin
        r.found = 1'b1;
        r.idx   = 5'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ring_osc_meter_if.sv
// ring_osc_meter_if: control/result bundle of the ring-oscillator meter.
//   start, ch_en                    - scan request and channel mask (master -> slave)
//   busy, ch_idx, count,
//   count_valid, overflow, done     - scan status and per-channel results
//   osc_out                         - raw ring outputs for observation
`timescale 1ns/1ps
interface ring_osc_meter_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic              start;
  logic [N_CH-1:0]   ch_en;
  logic              busy;
  logic [CH_W-1:0]   ch_idx;
  logic [CNT_W-1:0]  count;
  logic              count_valid;
  logic              overflow;
  logic              done;
  logic [N_CH-1:0]   osc_out;

  modport master (
    output start, ch_en,
    input  busy, ch_idx, count, count_valid, overflow, done, osc_out
  );

  modport slave (
    input  start, ch_en,
    output busy, ch_idx, count, count_valid, overflow, done, osc_out
  );
endinterface

// File: rtl/ring_osc_meter_cell.sv
// ring_osc_cell: one gated ring oscillator of STAGES inversions (odd).
//   en  - ring enable; when low the loop parks and osc is held at 0
//   osc - ring output, gated by en
`timescale 1ns/1ps
module ring_osc_cell #(
  parameter int STAGES       = 5,
  parameter int INV_DELAY_ns = 1
) (
  input  logic en,
  output logic osc
);
  logic [STAGES-1:0] w_n;

  // Stage 0 is a NAND with the enable, so the loop keeps an odd number of
  // inversions while running and settles to a static level when off.
`ifdef R_OSC_SYNTHESIS
  nand g_nand (w_n[0], en, w_n[STAGES-1]);
  for (genvar i = 1; i < STAGES; i++) begin : g_inv
    not g_not (w_n[i], w_n[i-1]);
  end
`else
  assign #(INV_DELAY_ns) w_n[0] = ~(en & w_n[STAGES-1]);
  for (genvar i = 1; i < STAGES; i++) begin : g_inv
    assign #(INV_DELAY_ns) w_n[i] = ~w_n[i-1];
  end
`endif

  assign osc = en & w_n[STAGES-1];
endmodule

// File: rtl/ring_osc_meter.sv
// ring_osc_meter: bank of N_CH gated ring oscillators plus a frequency meter.
// A scan walks the enabled channels from low to high; each is run for
// SETTLE_CYCLES, then its synchronized rising edges are counted for
// GATE_CYCLES and reported with a one-cycle count_valid strobe.
//   clk  - system clock (rising edge)
//   rst  - asynchronous active-high reset
//   bus  - ring_osc_meter_if slave: start/ch_en in, status/results/osc_out out
`timescale 1ns/1ps
module ring_osc_meter
  import ring_osc_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int NO_STAGES     = 5,
  parameter int INV_DELAY_ns  = 1,
  parameter int SETTLE_CYCLES = 8,
  parameter int GATE_CYCLES   = 1000,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  ring_osc_meter_if.slave   bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TMR_W = $clog2((GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES) + 1;

  state_t             r_state;
  logic [N_CH-1:0]    r_mask;
  logic [CH_W-1:0]    r_ch;
  logic [TMR_W-1:0]   r_tmr;
  logic [CNT_W-1:0]   r_ecnt, r_count;
  logic               r_eovf, r_ovf;
  logic               r_busy, r_cv, r_done;
  logic [2:0]         r_sync;   // [0]=sync1, [1]=sync2, [2]=sync3

  logic [N_CH-1:0]    w_en, w_osc;
  logic               w_osc_sel, w_edge;
  logic [CNT_W-1:0]   w_ecnt_nxt;
  logic               w_eovf_nxt;
  ch_sel_t            w_first, w_next;

  // Only the current channel runs, and only while settling or gating.
  // Decoded from registers so an asynchronous reset stops the ring at once.
  always_comb begin
    w_en = '0;
    if ((r_state == SETTLE) || (r_state == GATE)) w_en[r_ch] = 1'b1;
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ring
    ring_osc_cell #(
      .STAGES       (stages_of(NO_STAGES, c)),
      .INV_DELAY_ns (INV_DELAY_ns)
    ) u_cell (
      .en  (w_en[c]),
      .osc (w_osc[c])
    );
  end

  assign w_osc_sel = w_osc[r_ch];
  assign w_edge    = r_sync[1] & ~r_sync[2];

  // Saturating edge counter: an edge arriving at all-ones is lost and flagged.
  always_comb begin
    w_ecnt_nxt = r_ecnt;
    w_eovf_nxt = r_eovf;
    if (w_edge) begin
      if (&r_ecnt) w_eovf_nxt = 1'b1;
      else         w_ecnt_nxt = r_ecnt + 1'b1;
    end
  end

  assign w_first = next_ch(MAX_CH'(bus.ch_en), 0);
  assign w_next  = next_ch(MAX_CH'(r_mask), int'(r_ch) + 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_mask  <= '0;
      r_ch    <= '0;
      r_tmr   <= '0;
      r_ecnt  <= '0;
      r_eovf  <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_cv    <= 1'b0;
      r_done  <= 1'b0;
      r_sync  <= '0;
    end else begin
      r_sync <= {r_sync[1:0], w_osc_sel};
      r_cv   <= 1'b0;
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_mask <= bus.ch_en;
            r_busy <= 1'b1;
            if (w_first.found) begin
              r_state <= SETTLE;
              r_ch    <= CH_W'(w_first.idx);
              r_tmr   <= '0;
              r_sync  <= '0;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (r_tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
            r_state <= GATE;
            r_tmr   <= '0;
            r_ecnt  <= '0;
            r_eovf  <= 1'b0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        GATE: begin
          r_ecnt <= w_ecnt_nxt;
          r_eovf <= w_eovf_nxt;
          // The last window cycle's edge is folded straight into the result.
          if (r_tmr == TMR_W'(GATE_CYCLES - 1)) begin
            r_state <= REPORT;
            r_count <= w_ecnt_nxt;
            r_ovf   <= w_eovf_nxt;
            r_cv    <= 1'b1;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        REPORT: begin
          if (w_next.found) begin
            r_state <= SETTLE;
            r_ch    <= CH_W'(w_next.idx);
            r_tmr   <= '0;
            r_sync  <= '0;
          end else begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.ch_idx      = r_ch;
  assign bus.count       = r_count;
  assign bus.count_valid = r_cv;
  assign bus.overflow    = r_ovf;
  assign bus.done        = r_done;
  assign bus.osc_out     = w_osc;
endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
module tb_ring_osc_meter;
  import ring_osc_pkg::*;

  localparam int N_CH = 4, NOS = 5, INV = 1, SETTLE = 8, GATE = 1000, TCLK = 4;
  localparam int SCAN1 = SETTLE + GATE + 1;

  typedef struct {
    int ch;
    int cnt;
    int tol;
    int ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0, checks = 0;
  int   cyc = 0, busy_cyc = 0, last_cv = 0, done_cyc = 0;
  int   multi_on = 0, off_bad = 0;
  bit   sparse_ph = 1'b0;
  exp_t exp_q[$];
  exp_t exp8_q[$];
  exp_t e_mon, e_mon8;

  always #(TCLK/2) clk = ~clk;

  ring_osc_meter_if #(.N_CH(N_CH), .CNT_W(16)) bus();
  ring_osc_meter_if #(.N_CH(N_CH), .CNT_W(8))  bus8();

  ring_osc_meter #(
    .N_CH(N_CH), .NO_STAGES(NOS), .INV_DELAY_ns(INV),
    .SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(16)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  ring_osc_meter #(
    .N_CH(N_CH), .NO_STAGES(NOS), .INV_DELAY_ns(INV),
    .SETTLE_CYCLES(SETTLE), .GATE_CYCLES(GATE), .CNT_W(8)
  ) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic chk(input string tag, input longint obs, input longint exp, input int tol = 0);
    checks++;
    if ((obs < exp - tol) || (obs > exp + tol)) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Ideal edge count: gate window length over ring period 2*stages*delay.
  function automatic int exp_cnt(input int c);
    return (GATE * TCLK) / (2 * (NOS + 2 * c) * INV);
  endfunction

  // Output monitor / scoreboard pop.
  always @(negedge clk) begin
    cyc++;
    if (bus.busy) busy_cyc++;
    if ($countones(bus.osc_out) > 1) multi_on++;
    if (sparse_ph && (bus.osc_out[0] || bus.osc_out[2])) off_bad++;
    if (bus.done) done_cyc = cyc;
    if (bus.count_valid) begin
      last_cv = cyc;
      if (exp_q.size() == 0) chk("cv_extra", 1, 0);
      else begin
        e_mon = exp_q.pop_front();
        chk("ch_idx", longint'(bus.ch_idx), e_mon.ch);
        chk("count", longint'(bus.count), e_mon.cnt, e_mon.tol);
        chk("ovf", longint'(bus.overflow), e_mon.ovf);
      end
    end
    if (bus8.count_valid) begin
      if (exp8_q.size() == 0) chk("cv8_extra", 1, 0);
      else begin
        e_mon8 = exp8_q.pop_front();
        chk("ch_idx8", longint'(bus8.ch_idx), e_mon8.ch);
        chk("count8", longint'(bus8.count), e_mon8.cnt, e_mon8.tol);
        chk("ovf8", longint'(bus8.overflow), e_mon8.ovf);
      end
    end
  end

  // One scan on the 16-bit instance; poke>0 re-pulses start (with a changed
  // mask) that many cycles in, which must not disturb the scan.
  task automatic run_scan(input logic [N_CH-1:0] mask, input int poke);
    int n;
    n = 0;
    for (int c = 0; c < N_CH; c++)
      if (mask[c]) exp_q.push_back('{c, exp_cnt(c), 1, 0});
    @(negedge clk);
    busy_cyc    = 0;
    bus.ch_en   = mask;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_on", longint'(bus.busy), 1);
    while (!bus.done && n < 5 * SCAN1) begin
      if (poke > 0 && n == poke) begin
        bus.start = 1'b1;
        bus.ch_en = ~mask;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    chk("done_seen", longint'(bus.done), 1);
    @(negedge clk);
    #1;
    chk("done_1cyc", longint'(bus.done), 0);
    chk("busy_off", longint'(bus.busy), 0);
    chk("busy_cyc", busy_cyc, $countones(mask) * SCAN1 + 1);
    if (mask != 0) chk("done_lat", done_cyc - last_cv, 1);
    chk("sb_empty", exp_q.size(), 0);
    bus.ch_en = '0;
  endtask

  initial begin
    int n;
    bus.start  = 1'b0; bus.ch_en  = '0;
    bus8.start = 1'b0; bus8.ch_en = '0;
    #3;
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_cv", longint'(bus.count_valid), 0);
    chk("rst_count", longint'(bus.count), 0);
    chk("rst_ch", longint'(bus.ch_idx), 0);
    chk("rst_ovf", longint'(bus.overflow), 0);
    chk("rst_osc", longint'(bus.osc_out), 0);
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;

    // Saturation on the 8-bit instance, channel 0 only.
    exp8_q.push_back('{0, 255, 0, 1});
    @(negedge clk);
    bus8.ch_en = 4'b0001;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    n = 0;
    while (!bus8.done && n < 3 * SCAN1) begin
      @(negedge clk);
      n++;
    end
    chk("done8", longint'(bus8.done), 1);
    @(negedge clk); #1;
    chk("sb8_empty", exp8_q.size(), 0);

    // Full scan, with an ignored start during channel 0's gate window.
    run_scan(4'b1111, SETTLE + 50);
    chk("one_ring", multi_on, 0);

    // Sparse mask: channels 0 and 2 never run.
    sparse_ph = 1'b1;
    run_scan(4'b1010, 0);
    sparse_ph = 1'b0;
    chk("off_rings", off_bad, 0);

    // Empty mask.
    run_scan(4'b0000, 0);

    // Asynchronous reset in the gate window of channel 1.
    exp_q.push_back('{0, exp_cnt(0), 1, 0});
    @(negedge clk);
    bus.ch_en = 4'b1111;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (SCAN1 + SETTLE + 200) @(negedge clk);
    #1;
    chk("pre_busy", longint'(bus.busy), 1);
    chk("pre_ch", longint'(bus.ch_idx), 1);
    chk("pre_cnt", longint'(bus.count), exp_cnt(0), 1);
    rst = 1'b1;
    #0.5;
    chk("arst_busy", longint'(bus.busy), 0);
    chk("arst_cv", longint'(bus.count_valid), 0);
    chk("arst_osc", longint'(bus.osc_out), 0);
    chk("arst_count", longint'(bus.count), 0);
    chk("arst_ch", longint'(bus.ch_idx), 0);
    chk("sb_rst", exp_q.size(), 0);
    bus.ch_en = '0;
    @(negedge clk); #1 rst = 1'b0;

    run_scan(4'b1111, 0);
    chk("one_ring_end", multi_on, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ring_osc_meter.md
Name: ring_osc_meter

Overview:
Multi-channel ring-oscillator bank with an on-chip frequency meter. N_CH gated inverter rings of increasing length are enabled one at a time and measured against the system clock. Each ring output is brought into the clk domain through a 2-FF synchronizer, and its rising edges are counted over a fixed gate window. The block sits beside the synchronizer experiments as the characterisation and monitor path for on-chip oscillators.

Parameters:
N_CH, 4, number of oscillator channels (>=1)
NO_STAGES, 5, inverter count of channel 0 (odd, >=3); channel c has NO_STAGES+2*c stages
INV_DELAY_ns, 1, simulation delay per inverter; ignored when R_OSC_SYNTHESIS is defined
SETTLE_CYCLES, 8, clk cycles after enabling a ring before counting starts (>=3)
GATE_CYCLES, 1000, clk cycles in the counting window (>=1)
CNT_W, 16, edge-counter width

Ports:
clk  in  1  system clock, all sequential logic on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  single-cycle request to begin a scan; sampled only in IDLE
ch_en  in  N_CH  channel mask for the scan; latched on accepted start
busy  out  1  high while a scan is in progress
ch_idx  out  $clog2(N_CH) (min 1)  channel whose result is on count
count  out  CNT_W  rising-edge count of ch_idx over the gate window
count_valid  out  1  1-cycle strobe qualifying ch_idx, count and overflow
overflow  out  1  count saturated during this window
done  out  1  1-cycle pulse at end of scan
osc_out  out  N_CH  raw ring outputs (for scope/bench); 0 when disabled

Behaviour:
- Reset (asynchronous assert): FSM=IDLE; all ring enables=0; busy, ch_idx, count, count_valid, overflow and done=0; synchronizer flops=0; latched mask=0.
- Rings: each ring is an odd inverter loop gated by its own enable. When disabled, the ring output is forced to 0. At most one ring is enabled at a time, namely the current channel, and only during SETTLE and GATE.
- Synchronizer: sync1 -> sync2 -> sync3 on clk. A counted edge is sync2 & ~sync3. All three flops are cleared on entry to SETTLE.
- FSM states: IDLE, SETTLE, GATE, REPORT, DONE.
- IDLE: on start=1, latch ch_en and set busy=1 next cycle.
  - If the latched mask is 0: go to DONE.
  - Otherwise: go to SETTLE with ch_idx = lowest set bit.
  - start in any state other than IDLE is ignored.
- SETTLE: enable the ring. Stay SETTLE_CYCLES cycles, then go to GATE with the edge counter = 0.
- GATE: exactly GATE_CYCLES cycles.
  - The counter increments on each edge.
  - At all-ones the counter holds and sets the overflow flag.
  - On exit the ring is disabled.
- REPORT: 1 cycle with count_valid=1; count, overflow and ch_idx are stable. count and overflow hold their values until the next REPORT.
  - If a higher enabled channel remains: go to SETTLE with ch_idx = next set bit.
  - Otherwise: go to DONE.
- DONE: 1 cycle with done=1 and busy=1. The next cycle has busy=0 and state IDLE.
- Latency per channel = SETTLE_CYCLES + GATE_CYCLES + 1 cycles.
- Aliasing: valid only for oscillator frequency < f_clk/2. Higher frequencies produce undercounts by design, not an error.
- Mid-scan changes to ch_en have no effect.
- Reset mid-scan disables the ring immediately and returns all outputs to reset values.

Decomposition:
- Package ring_osc_pkg:
  - FSM state enum (IDLE, SETTLE, GATE, REPORT, DONE).
  - Function stages_of(c) = NO_STAGES+2*c.
  - Function next_ch(mask, from) returning the next set bit and a found flag.
- Sub-module ring_osc_cell:
  - Parameters STAGES and INV_DELAY_ns; ports en and osc.
  - Generate loop of not primitives, with delay under `ifndef R_OSC_SYNTHESIS.
  - Output forced to 0 when en=0.
  - Instantiated N_CH times with STAGES = stages_of(c).

Test Plan:
- Nominal scan: clk period 4 ns, defaults, ch_en=4'b1111, start → four count_valid strobes, ch_idx 0,1,2,3, counts 400, 285/286, 222/223, 181/182 (±1), overflow=0, done 1 cycle after the last REPORT. Total busy = 4*(8+1000+1)+1 cycles.
- Sparse mask: ch_en=4'b1010 → strobes only for ch_idx 1 then 3. osc_out[0] and osc_out[2] stay 0 throughout; at most one osc_out bit toggles at any time.
- Empty mask: ch_en=0, start → busy=1, then done=1 on the second cycle, no count_valid, back to IDLE.
- Overflow: CNT_W=8, GATE_CYCLES=1000, ch_en=4'b0001 → count=255, overflow=1. A following scan with CNT_W default clears overflow.
- Ignored start: pulse start again during GATE → no restart, strobe sequence unchanged.
- Reset mid-GATE: assert rst asynchronously between clk edges in GATE of channel 1 → busy, count_valid and osc_out drop to 0 without waiting for a clk edge. A new start after release gives a normal full scan.
